// File: rtl/ulpi_init_seq_pkg.sv
// ulpi_init_seq_pkg
// Shared definitions for the ULPI PHY init sequencer:
//   - register addresses and init values written after START
//   - length of the init table
//   - sequencer state encoding
//   - init_entry(): combinational table lookup by write index
package ulpi_init_seq_pkg;

  localparam int INIT_LEN = 3;

  localparam logic [5:0] REG_FUNC_CTRL = 6'h04;
  localparam logic [5:0] REG_OTG_CTRL  = 6'h0A;
  localparam logic [5:0] REG_IFC_CTRL  = 6'h07;

  // Function Control: full-speed transceiver, non-driving opmode, SuspendM=1
  localparam logic [7:0] VAL_FUNC_CTRL = 8'h49;
  // OTG Control: DP/DM pulldowns off
  localparam logic [7:0] VAL_OTG_CTRL  = 8'h00;
  localparam logic [7:0] VAL_IFC_CTRL  = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DELAY     = 3'd1,
    ST_WAIT_BUS  = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_FINISH    = 3'd6,
    ST_FAIL      = 3'd7
  } state_t;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] data;
  } reg_write_t;

  // Out-of-range indices return an all-zero entry.
  function automatic reg_write_t init_entry(input logic [1:0] idx);
    reg_write_t e;
    e.addr = '0;
    e.data = '0;
    case (idx)
      2'd0: begin e.addr = REG_FUNC_CTRL; e.data = VAL_FUNC_CTRL; end
      2'd1: begin e.addr = REG_OTG_CTRL;  e.data = VAL_OTG_CTRL;  end
      2'd2: begin e.addr = REG_IFC_CTRL;  e.data = VAL_IFC_CTRL;  end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ulpi_init_seq_if.sv
// ulpi_init_seq_if
// Control/handshake bundle of the ULPI init sequencer.
//   start      : one-cycle pulse that begins the init sequence
//   dir        : ULPI DIR pin, high while the PHY owns the bus
//   wr_busy    : busy flag of the downstream register-write stage
//   write_data : one-cycle request to the register-write stage
//   addr/data  : register address/value of the current write
//   busy       : sequence running
//   done/error : sticky completion / timeout flags
// master = sequencer side, slave = environment (PHY + register writer).
interface ulpi_init_seq_if;

  logic       start;
  logic       dir;
  logic       wr_busy;
  logic       write_data;
  logic [5:0] addr;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    input  start, dir, wr_busy,
    output write_data, addr, data, busy, done, error
  );

  modport slave (
    output start, dir, wr_busy,
    input  write_data, addr, data, busy, done, error
  );

endinterface

// File: rtl/ulpi_init_seq.sv
// ulpi_init_seq
// After START, waits STARTUP_CYCLES, then issues the three-entry init
// table to the ULPI register-write stage, one write at a time, waiting for
// the PHY to release the bus (DIR low) and for the writer to be idle.
// Each write must be acknowledged (WR_BUSY rising) within 2 cycles and
// must complete within TIMEOUT_CYCLES, otherwise the sequence stops in
// FAIL with error held. done/error stay set until the next START or reset.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : ulpi_init_seq_if.master (start/dir/wr_busy in, write request,
//         addr/data and busy/done/error status out)
module ulpi_init_seq
  import ulpi_init_seq_pkg::*;
#(
  parameter int STARTUP_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  ulpi_init_seq_if.master bus
);

  localparam int CNT_MAX = (STARTUP_CYCLES > TIMEOUT_CYCLES) ? STARTUP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       IDX_LAST     = 2'(INIT_LEN - 1);

  state_t           state_reg, state_next;
  logic [1:0]       idx_reg, idx_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             dir_reg;

  reg_write_t       entry;
  reg_write_t       out_entry;
  logic             wr_req;
  logic             busy;
  logic             done;
  logic             error;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
  assign entry   = init_entry(idx_reg);

  // DIR is sampled into a flop before use, like a pad input register, so
  // the bus-free decision acts one cycle after DIR falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      dir_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      dir_reg   <= bus.dir;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    out_entry  = '0;
    wr_req     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;

    case (state_reg)
      ST_IDLE, ST_FINISH, ST_FAIL: begin
        done  = (state_reg == ST_FINISH);
        error = (state_reg == ST_FAIL);
        if (bus.start) begin
          state_next = ST_DELAY;
          idx_next   = '0;
          cnt_next   = '0;
        end
      end

      ST_DELAY: begin
        busy = 1'b1;
        if (cnt_reg >= DELAY_LAST) begin
          state_next = ST_WAIT_BUS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_WAIT_BUS: begin
        busy = 1'b1;
        if (idx_reg > IDX_LAST) begin
          state_next = ST_FAIL;
        end else if (!dir_reg && !bus.wr_busy) begin
          state_next = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        busy       = 1'b1;
        wr_req     = 1'b1;
        out_entry  = entry;
        state_next = ST_WAIT_ACK;
        cnt_next   = '0;
      end

      // Two cycles of grace for the writer to raise its busy flag.
      ST_WAIT_ACK: begin
        busy      = 1'b1;
        out_entry = entry;
        if (bus.wr_busy) begin
          state_next = ST_WAIT_DONE;
          cnt_next   = '0;
        end else if (cnt_reg >= 1) begin
          state_next = ST_FAIL;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      // DIR is deliberately ignored here; only the timeout can abort.
      ST_WAIT_DONE: begin
        busy      = 1'b1;
        out_entry = entry;
        if (!bus.wr_busy) begin
          idx_next   = idx_reg + 1'b1;
          cnt_next   = '0;
          state_next = (idx_reg == IDX_LAST) ? ST_FINISH : ST_WAIT_BUS;
        end else if (cnt_reg >= TIMEOUT_LAST) begin
          state_next = ST_FAIL;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.write_data = wr_req;
  assign bus.addr       = out_entry.addr;
  assign bus.data       = out_entry.data;
  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.error      = error;

endmodule

// File: tb/tb_ulpi_init_seq.sv
// tb_ulpi_init_seq
// Self-checking bench for ulpi_init_seq. A behavioural register-writer
// logs every write request (cycle, addr, data) and answers it with a busy
// window of configurable length; the expected write list and cycle timing
// are computed from the sequencer's documented rules with plain arithmetic.
module tb_ulpi_init_seq;

  localparam int S = 16;
  localparam int T = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;

  ulpi_init_seq_if bus ();

  ulpi_init_seq #(.STARTUP_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected init table
  logic [5:0] exp_addr [3] = '{6'h04, 6'h0A, 6'h07};
  logic [7:0] exp_data [3] = '{8'h49, 8'h00, 8'h00};

  // Writer model controls and request log
  int         busy_lens [3] = '{4, 4, 4};
  int         req_n         = 0;
  int         stuck_req     = 0;
  bit         silent        = 1'b0;
  bit         release_stuck = 1'b0;
  int         rec_cyc  [$];
  logic [5:0] rec_addr [$];
  logic [7:0] rec_data [$];

  // Writer: raises wr_busy the cycle after a request, for busy_lens cycles
  // (or forever for the stuck request, or never when silent).
  initial begin
    bus.wr_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.write_data === 1'b1) begin
        rec_cyc.push_back(cyc);
        rec_addr.push_back(bus.addr);
        rec_data.push_back(bus.data);
        req_n++;
        if (!silent) begin
          @(posedge clk);
          #1 bus.wr_busy = 1'b1;
          if (req_n == stuck_req) wait (release_stuck);
          else repeat (busy_lens[(req_n - 1) % 3]) @(posedge clk);
          #1 bus.wr_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    rec_cyc.delete();
    rec_addr.delete();
    rec_data.delete();
    req_n = 0;
  endtask

  // START is driven during cycle s and sampled at the following edge.
  task automatic pulse_start(output int s);
    @(posedge clk);
    #1 bus.start = 1'b1;
    s = cyc;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic run_until_end(input int bound, output int end_cyc, output bit hit);
    hit = 1'b0;
    end_cyc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.error === 1'b1) begin
        hit = 1'b1;
        end_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    rst       = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.write_data !== 1'b0) begin errors++; $display("FAIL reset_write_data: got %0b expected 0", bus.write_data); end
    checks++; if (bus.addr !== 6'h00) begin errors++; $display("FAIL reset_addr: got %0h expected 0", bus.addr); end
    checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.data); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b expected 0", bus.done); end
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL reset_error: got %0b expected 0", bus.error); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.write_data !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %0b wr %0b expected 0 0", bus.busy, bus.write_data); end
    $display("test_reset: done");
  endtask

  task automatic test_nominal();
    int s, e, exp_cyc, exp_end;
    bit hit;
    busy_lens = '{4, 4, 4};
    clear_log();
    pulse_start(s);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nominal_busy: got %0b expected 1", bus.busy); end
    run_until_end(S + 100, e, hit);
    checks++; if (!hit) begin errors++; $display("FAIL nominal_end: got no done/error expected done"); end
    checks++; if (rec_cyc.size() != 3) begin errors++; $display("FAIL nominal_count: got %0d writes expected 3", rec_cyc.size()); end
    exp_cyc = s + S + 2;
    for (int i = 0; i < rec_cyc.size() && i < 3; i++) begin
      checks++; if (rec_addr[i] !== exp_addr[i] || rec_data[i] !== exp_data[i]) begin errors++; $display("FAIL nominal_entry%0d: got %0h/%0h expected %0h/%0h", i, rec_addr[i], rec_data[i], exp_addr[i], exp_data[i]); end
      checks++; if (rec_cyc[i] != exp_cyc) begin errors++; $display("FAIL nominal_time%0d: got cycle %0d expected %0d", i, rec_cyc[i], exp_cyc); end
      $display("nominal write %0d: addr %0h data %0h cycle %0d", i, rec_addr[i], rec_data[i], rec_cyc[i]);
      exp_cyc = exp_cyc + busy_lens[i] + 3;
    end
    exp_end = s + S + 2 + (busy_lens[0] + 3) + (busy_lens[1] + 3) + busy_lens[2] + 2;
    checks++; if (e != exp_end) begin errors++; $display("FAIL nominal_done_time: got cycle %0d expected %0d", e, exp_end); end
    checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL nominal_status: got done %0b busy %0b error %0b expected 1 0 0", bus.done, bus.busy, bus.error); end
  endtask

  task automatic test_back_to_back();
    int s, e, exp_cyc, exp_end;
    bit hit;
    for (int it = 0; it < 3; it++) begin
      for (int k = 0; k < 3; k++) busy_lens[k] = $urandom_range(1, 8);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      clear_log();
      pulse_start(s);
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b%0d_done_clear: got %0b expected 0", it, bus.done); end
      run_until_end(S + 100, e, hit);
      checks++; if (!hit || rec_cyc.size() != 3) begin errors++; $display("FAIL b2b%0d_count: got %0d writes (end %0b) expected 3", it, rec_cyc.size(), hit); end
      exp_cyc = s + S + 2;
      exp_end = 0;
      for (int i = 0; i < rec_cyc.size() && i < 3; i++) begin
        checks++; if (rec_addr[i] !== exp_addr[i] || rec_data[i] !== exp_data[i] || rec_cyc[i] != exp_cyc) begin errors++; $display("FAIL b2b%0d_write%0d: got %0h/%0h@%0d expected %0h/%0h@%0d", it, i, rec_addr[i], rec_data[i], rec_cyc[i], exp_addr[i], exp_data[i], exp_cyc); end
        $display("b2b %0d write %0d: addr %0h data %0h cycle %0d busy_len %0d", it, i, rec_addr[i], rec_data[i], rec_cyc[i], busy_lens[i]);
        exp_end = exp_cyc + busy_lens[i] + 2;
        exp_cyc = exp_cyc + busy_lens[i] + 3;
      end
      checks++; if (e != exp_end || bus.done !== 1'b1) begin errors++; $display("FAIL b2b%0d_done: got done %0b at %0d expected 1 at %0d", it, bus.done, e, exp_end); end
    end
  endtask

  task automatic test_dir_hold();
    int s, e, d;
    bit hit;
    busy_lens = '{2, 3, 2};
    bus.dir = 1'b1;
    clear_log();
    pulse_start(s);
    repeat (S + 50) @(posedge clk);
    #1;
    checks++; if (rec_cyc.size() != 0) begin errors++; $display("FAIL dir_hold_no_write: got %0d writes expected 0", rec_cyc.size()); end
    d = cyc;
    bus.dir = 1'b0;
    run_until_end(S + 100, e, hit);
    checks++; if (rec_cyc.size() != 3 || !hit) begin errors++; $display("FAIL dir_hold_count: got %0d writes expected 3", rec_cyc.size()); end
    if (rec_cyc.size() > 0) begin
      checks++; if (rec_cyc[0] != d + 2 || rec_addr[0] !== exp_addr[0]) begin errors++; $display("FAIL dir_hold_first: got %0h@%0d expected %0h@%0d", rec_addr[0], rec_cyc[0], exp_addr[0], d + 2); end
      $display("dir_hold: dir fell cycle %0d, first write cycle %0d", d, rec_cyc[0]);
    end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL dir_hold_done: got %0b expected 1", bus.done); end
  endtask

  task automatic test_start_ignored();
    int s, s2, e, exp_cyc;
    bit hit;
    busy_lens = '{4, 4, 4};
    clear_log();
    pulse_start(s);
    repeat (3) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < S + 50 && rec_cyc.size() < 1; i++) begin @(negedge clk); #1; end
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    run_until_end(S + 100, e, hit);
    checks++; if (rec_cyc.size() != 3 || !hit) begin errors++; $display("FAIL ignore_count: got %0d writes expected 3", rec_cyc.size()); end
    exp_cyc = s + S + 2;
    for (int i = 0; i < rec_cyc.size() && i < 3; i++) begin
      checks++; if (rec_cyc[i] != exp_cyc || rec_addr[i] !== exp_addr[i]) begin errors++; $display("FAIL ignore_write%0d: got %0h@%0d expected %0h@%0d", i, rec_addr[i], rec_cyc[i], exp_addr[i], exp_cyc); end
      exp_cyc = exp_cyc + busy_lens[i] + 3;
    end
    // START after DONE reruns the whole table
    clear_log();
    pulse_start(s2);
    @(negedge clk);
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rerun_clear: got done %0b busy %0b expected 0 1", bus.done, bus.busy); end
    run_until_end(S + 100, e, hit);
    checks++; if (rec_cyc.size() != 3 || bus.done !== 1'b1) begin errors++; $display("FAIL rerun_count: got %0d writes done %0b expected 3 1", rec_cyc.size(), bus.done); end
    $display("start_ignored: first run start %0d, rerun start %0d, rerun writes %0d", s, s2, rec_cyc.size());
  endtask

  task automatic test_timeout();
    int s, e;
    bit hit;
    busy_lens = '{3, 3, 3};
    stuck_req = 2;
    release_stuck = 1'b0;
    clear_log();
    pulse_start(s);
    run_until_end(S + T + 100, e, hit);
    checks++; if (!hit || rec_cyc.size() != 2) begin errors++; $display("FAIL timeout_count: got %0d writes expected 2", rec_cyc.size()); end
    if (rec_cyc.size() == 2) begin
      checks++; if (e != rec_cyc[1] + 2 + T) begin errors++; $display("FAIL timeout_time: got cycle %0d expected %0d", e, rec_cyc[1] + 2 + T); end
    end
    checks++; if (bus.error !== 1'b1 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_status: got error %0b done %0b busy %0b expected 1 0 0", bus.error, bus.done, bus.busy); end
    release_stuck = 1'b1;
    repeat (4) @(negedge clk);
    release_stuck = 1'b0;
    stuck_req = 0;
    checks++; if (bus.error !== 1'b1) begin errors++; $display("FAIL timeout_hold: got %0b expected 1", bus.error); end
    $display("timeout: error at cycle %0d", e);
  endtask

  task automatic test_no_ack();
    int s, e;
    bit hit;
    silent = 1'b1;
    clear_log();
    pulse_start(s);
    @(negedge clk);
    checks++; if (bus.error !== 1'b0) begin errors++; $display("FAIL no_ack_clear: got %0b expected 0", bus.error); end
    run_until_end(S + 50, e, hit);
    checks++; if (!hit || rec_cyc.size() != 1) begin errors++; $display("FAIL no_ack_count: got %0d writes expected 1", rec_cyc.size()); end
    if (rec_cyc.size() == 1) begin
      checks++; if (e != rec_cyc[0] + 3) begin errors++; $display("FAIL no_ack_time: got cycle %0d expected %0d", e, rec_cyc[0] + 3); end
    end
    checks++; if (bus.error !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL no_ack_status: got error %0b busy %0b done %0b expected 1 0 0", bus.error, bus.busy, bus.done); end
    silent = 1'b0;
    $display("no_ack: error at cycle %0d", e);
  endtask

  task automatic test_reset_mid();
    int s, e;
    bit hit;
    busy_lens = '{2, 10, 2};
    clear_log();
    pulse_start(s);
    for (int i = 0; i < S + 100 && rec_cyc.size() < 2; i++) begin @(negedge clk); #1; end
    checks++; if (rec_cyc.size() != 2) begin errors++; $display("FAIL rstmid_reach: got %0d writes expected 2", rec_cyc.size()); end
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b1 || bus.addr !== exp_addr[1]) begin errors++; $display("FAIL rstmid_wait_done: got busy %0b addr %0h expected 1 %0h", bus.busy, bus.addr, exp_addr[1]); end
    rst = 1'b0;
    #1;
    checks++; if (bus.write_data !== 1'b0 || bus.addr !== 6'h00 || bus.data !== 8'h00) begin errors++; $display("FAIL rstmid_bus: got wr %0b addr %0h data %0h expected 0 0 0", bus.write_data, bus.addr, bus.data); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.error !== 1'b0) begin errors++; $display("FAIL rstmid_status: got busy %0b done %0b error %0b expected 0 0 0", bus.busy, bus.done, bus.error); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.write_data !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: got wr %0b busy %0b expected 0 0", bus.write_data, bus.busy); end
    repeat (12) @(posedge clk);
    busy_lens = '{2, 3, 4};
    clear_log();
    pulse_start(s);
    run_until_end(S + 100, e, hit);
    checks++; if (rec_cyc.size() != 3 || bus.done !== 1'b1) begin errors++; $display("FAIL rstmid_replay: got %0d writes done %0b expected 3 1", rec_cyc.size(), bus.done); end
    for (int i = 0; i < rec_cyc.size() && i < 3; i++) begin
      checks++; if (rec_addr[i] !== exp_addr[i] || rec_data[i] !== exp_data[i]) begin errors++; $display("FAIL rstmid_entry%0d: got %0h/%0h expected %0h/%0h", i, rec_addr[i], rec_data[i], exp_addr[i], exp_data[i]); end
      $display("reset_mid replay write %0d: addr %0h data %0h cycle %0d", i, rec_addr[i], rec_data[i], rec_cyc[i]);
    end
    if (rec_cyc.size() > 0) begin
      checks++; if (rec_cyc[0] != s + S + 2) begin errors++; $display("FAIL rstmid_first_time: got cycle %0d expected %0d", rec_cyc[0], s + S + 2); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dir   = 1'b0;
    test_reset();
    test_nominal();
    test_back_to_back();
    test_dir_hold();
    test_start_ignored();
    test_timeout();
    test_no_ack();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
